// File: rtl/fd_em_pipe_reg_if.sv
// rtl/fd_em_pipe_reg_if.sv - FD-to-EM pipeline register bundle: FD capture side, EM presentation side, stall and debug
interface fd_em_pipe_reg_if #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 8
);
    logic              enable;
    logic              flush;

    logic [DATA_W-1:0] alu_source_1_data_forwarded;
    logic [DATA_W-1:0] alu_source_2_data_forwarded;
    logic [DATA_W-1:0] read_data_2_forwarded;
    logic [2:0]        reg_source_1_addr_fd;
    logic [1:0]        reg_source_2_addr_fd;
    logic              alu_source_1_select;
    logic [1:0]        alu_source_2_select;
    logic [2:0]        reg_dest_addr_fd;
    logic [2:0]        op_code_fd;
    logic              reg_write_fd;
    logic              mem_read_fd;
    logic              mem_write_fd;

    logic [DATA_W-1:0] alu_source_1_data_em;
    logic [DATA_W-1:0] alu_source_2_data_em;
    logic [DATA_W-1:0] read_data_2_em;
    logic [2:0]        reg_dest_addr_em;
    logic [2:0]        op_code_em;
    logic              reg_write_em;
    logic              mem_read_em;
    logic              mem_write_em;
    logic              valid_em;
    logic              stall_fd;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output enable, flush,
        output alu_source_1_data_forwarded, alu_source_2_data_forwarded, read_data_2_forwarded,
        output reg_source_1_addr_fd, reg_source_2_addr_fd, alu_source_1_select, alu_source_2_select,
        output reg_dest_addr_fd, op_code_fd, reg_write_fd, mem_read_fd, mem_write_fd,
        input  alu_source_1_data_em, alu_source_2_data_em, read_data_2_em,
        input  reg_dest_addr_em, op_code_em, reg_write_em, mem_read_em, mem_write_em,
        input  valid_em, stall_fd, bubble_count
    );

    modport slave (
        input  enable, flush,
        input  alu_source_1_data_forwarded, alu_source_2_data_forwarded, read_data_2_forwarded,
        input  reg_source_1_addr_fd, reg_source_2_addr_fd, alu_source_1_select, alu_source_2_select,
        input  reg_dest_addr_fd, op_code_fd, reg_write_fd, mem_read_fd, mem_write_fd,
        output alu_source_1_data_em, alu_source_2_data_em, read_data_2_em,
        output reg_dest_addr_em, op_code_em, reg_write_em, mem_read_em, mem_write_em,
        output valid_em, stall_fd, bubble_count
    );
endinterface

// File: rtl/fd_em_pipe_reg.sv
// rtl/fd_em_pipe_reg.sv - FD/EM pipeline register with load-use stall, flush, freeze and bubble counter
module fd_em_pipe_reg #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    fd_em_pipe_reg_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] alu_src_1_q;
    logic [DATA_W-1:0] alu_src_2_q;
    logic [DATA_W-1:0] read_data_2_q;
    logic [2:0]        reg_dest_q;
    logic [2:0]        op_code_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [CNT_W-1:0]  bubble_cnt_q;

    logic              valid_q;
    logic              src_1_match;
    logic              src_2_match;
    logic              hazard;

    // Only a normal load leaves a real instruction in EM, so the state itself is the valid bit.
    assign valid_q = (state == ST_RUN);

    assign src_1_match = (reg_dest_q == bus.reg_source_1_addr_fd) && !bus.alu_source_1_select;
    assign src_2_match = (reg_dest_q == {1'b0, bus.reg_source_2_addr_fd})
                         && (bus.alu_source_2_select == 2'b00);

    assign hazard = valid_q && mem_read_q && reg_write_q && (reg_dest_q != 3'd0)
                    && (src_1_match || src_2_match);

    assign bus.stall_fd = bus.enable & hazard & ~bus.flush & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            alu_src_1_q   <= '0;
            alu_src_2_q   <= '0;
            read_data_2_q <= '0;
            reg_dest_q    <= '0;
            op_code_q     <= '0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            bubble_cnt_q  <= '0;
        end else if (bus.enable) begin
            if (bus.flush || hazard) begin
                // Bubble: operand registers keep stale data, only control and tags are squashed.
                state       <= ST_BUBBLE;
                reg_dest_q  <= '0;
                op_code_q   <= '0;
                reg_write_q <= 1'b0;
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
                if (bubble_cnt_q != {CNT_W{1'b1}}) begin
                    bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
                end
            end else begin
                state         <= ST_RUN;
                alu_src_1_q   <= bus.alu_source_1_data_forwarded;
                alu_src_2_q   <= bus.alu_source_2_data_forwarded;
                read_data_2_q <= bus.read_data_2_forwarded;
                reg_dest_q    <= bus.reg_dest_addr_fd;
                op_code_q     <= bus.op_code_fd;
                reg_write_q   <= bus.reg_write_fd;
                mem_read_q    <= bus.mem_read_fd;
                mem_write_q   <= bus.mem_write_fd;
            end
        end
    end

    assign bus.alu_source_1_data_em = alu_src_1_q;
    assign bus.alu_source_2_data_em = alu_src_2_q;
    assign bus.read_data_2_em       = read_data_2_q;
    assign bus.reg_dest_addr_em     = reg_dest_q;
    assign bus.op_code_em           = op_code_q;
    assign bus.reg_write_em         = reg_write_q;
    assign bus.mem_read_em          = mem_read_q;
    assign bus.mem_write_em         = mem_write_q;
    assign bus.valid_em             = valid_q;
    assign bus.bubble_count         = bubble_cnt_q;
endmodule

// File: tb/tb_fd_em_pipe_reg.sv
// tb/tb_fd_em_pipe_reg.sv - table-driven self-checking bench for fd_em_pipe_reg
module tb_fd_em_pipe_reg;
    localparam int DATA_W = 10;
    localparam int CNT_W  = 8;
    localparam int NVEC   = 19;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fd_em_pipe_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    fd_em_pipe_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rst, en, fl;
        int a1, a2, rd2;
        int rs1, rs2, s1sel, s2sel;
        int rd, op, rw, mr, mw;
        int x_stall;
        int x_a1, x_a2, x_rd2, x_rd, x_op, x_rw, x_mr, x_mw, x_valid, x_cnt;
    } vec_t;

    vec_t tbl [NVEC];

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (vector %0d): got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset                           = v.rst[0];
        bus.enable                      = v.en[0];
        bus.flush                       = v.fl[0];
        bus.alu_source_1_data_forwarded = v.a1[DATA_W-1:0];
        bus.alu_source_2_data_forwarded = v.a2[DATA_W-1:0];
        bus.read_data_2_forwarded       = v.rd2[DATA_W-1:0];
        bus.reg_source_1_addr_fd        = v.rs1[2:0];
        bus.reg_source_2_addr_fd        = v.rs2[1:0];
        bus.alu_source_1_select         = v.s1sel[0];
        bus.alu_source_2_select         = v.s2sel[1:0];
        bus.reg_dest_addr_fd            = v.rd[2:0];
        bus.op_code_fd                  = v.op[2:0];
        bus.reg_write_fd                = v.rw[0];
        bus.mem_read_fd                 = v.mr[0];
        bus.mem_write_fd                = v.mw[0];
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        drive(v);
        #1;
        chk("stall_fd", idx, int'(bus.stall_fd), v.x_stall);
        @(posedge clk);
        #1;
        chk("alu_source_1_data_em", idx, int'(bus.alu_source_1_data_em), v.x_a1);
        chk("alu_source_2_data_em", idx, int'(bus.alu_source_2_data_em), v.x_a2);
        chk("read_data_2_em",       idx, int'(bus.read_data_2_em),       v.x_rd2);
        chk("reg_dest_addr_em",     idx, int'(bus.reg_dest_addr_em),     v.x_rd);
        chk("op_code_em",           idx, int'(bus.op_code_em),           v.x_op);
        chk("reg_write_em",         idx, int'(bus.reg_write_em),         v.x_rw);
        chk("mem_read_em",          idx, int'(bus.mem_read_em),          v.x_mr);
        chk("mem_write_em",         idx, int'(bus.mem_write_em),         v.x_mw);
        chk("valid_em",             idx, int'(bus.valid_em),             v.x_valid);
        chk("bubble_count",         idx, int'(bus.bubble_count),         v.x_cnt);
    endtask

    initial begin
        //          rst en fl  a1     a2     rd2    rs1 rs2 s1 s2  rd op rw mr mw  stall  a1     a2     rd2    rd op rw mr mw v  cnt
        tbl[0]  = '{1, 1, 0, 'h3FF, 'h3FF, 'h3FF, 2, 1, 0, 0, 5, 7, 1, 1, 1, 0, 'h000, 'h000, 'h000, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 'h005, 'h011, 'h022, 0, 0, 1, 1, 3, 2, 1, 0, 0, 0, 'h005, 'h011, 'h022, 3, 2, 1, 0, 0, 1, 0};
        tbl[2]  = '{0, 1, 0, 'h0AA, 'h0BB, 'h0CC, 1, 1, 0, 0, 2, 4, 1, 1, 0, 0, 'h0AA, 'h0BB, 'h0CC, 2, 4, 1, 1, 0, 1, 0};
        tbl[3]  = '{0, 1, 0, 'h111, 'h122, 'h133, 2, 0, 0, 1, 4, 1, 1, 0, 0, 1, 'h0AA, 'h0BB, 'h0CC, 0, 0, 0, 0, 0, 0, 1};
        tbl[4]  = '{0, 1, 0, 'h111, 'h122, 'h133, 2, 0, 0, 1, 4, 1, 1, 0, 0, 0, 'h111, 'h122, 'h133, 4, 1, 1, 0, 0, 1, 1};
        tbl[5]  = '{0, 1, 0, 'h200, 'h201, 'h202, 0, 0, 1, 1, 2, 4, 1, 1, 0, 0, 'h200, 'h201, 'h202, 2, 4, 1, 1, 0, 1, 1};
        tbl[6]  = '{0, 1, 0, 'h210, 'h211, 'h212, 2, 2, 1, 1, 1, 3, 1, 1, 0, 0, 'h210, 'h211, 'h212, 1, 3, 1, 1, 0, 1, 1};
        tbl[7]  = '{0, 1, 0, 'h220, 'h221, 'h222, 0, 1, 1, 0, 5, 5, 1, 0, 1, 1, 'h210, 'h211, 'h212, 0, 0, 0, 0, 0, 0, 2};
        tbl[8]  = '{0, 1, 0, 'h220, 'h221, 'h222, 0, 1, 1, 0, 5, 5, 1, 0, 1, 0, 'h220, 'h221, 'h222, 5, 5, 1, 0, 1, 1, 2};
        tbl[9]  = '{0, 1, 0, 'h230, 'h231, 'h232, 0, 0, 1, 1, 0, 4, 1, 1, 0, 0, 'h230, 'h231, 'h232, 0, 4, 1, 1, 0, 1, 2};
        tbl[10] = '{0, 1, 0, 'h240, 'h241, 'h242, 0, 0, 0, 0, 6, 4, 1, 1, 0, 0, 'h240, 'h241, 'h242, 6, 4, 1, 1, 0, 1, 2};
        tbl[11] = '{0, 1, 1, 'h250, 'h251, 'h252, 6, 0, 0, 1, 7, 6, 1, 0, 0, 0, 'h240, 'h241, 'h242, 0, 0, 0, 0, 0, 0, 3};
        tbl[12] = '{0, 1, 0, 'h155, 'h156, 'h157, 0, 0, 1, 1, 7, 6, 1, 0, 0, 0, 'h155, 'h156, 'h157, 7, 6, 1, 0, 0, 1, 3};
        tbl[13] = '{0, 0, 0, 'h3AA, 'h3AB, 'h3AC, 7, 3, 0, 0, 1, 1, 0, 1, 1, 0, 'h155, 'h156, 'h157, 7, 6, 1, 0, 0, 1, 3};
        tbl[14] = '{0, 0, 1, 'h3AA, 'h3AB, 'h3AC, 7, 3, 0, 0, 1, 1, 0, 1, 1, 0, 'h155, 'h156, 'h157, 7, 6, 1, 0, 0, 1, 3};
        tbl[15] = '{0, 0, 0, 'h3AA, 'h3AB, 'h3AC, 7, 3, 0, 0, 1, 1, 0, 1, 1, 0, 'h155, 'h156, 'h157, 7, 6, 1, 0, 0, 1, 3};
        tbl[16] = '{0, 1, 0, 'h300, 'h301, 'h302, 0, 0, 1, 1, 3, 4, 1, 1, 0, 0, 'h300, 'h301, 'h302, 3, 4, 1, 1, 0, 1, 3};
        tbl[17] = '{0, 0, 0, 'h310, 'h311, 'h312, 3, 0, 0, 1, 4, 1, 1, 0, 0, 0, 'h300, 'h301, 'h302, 3, 4, 1, 1, 0, 1, 3};
        tbl[18] = '{1, 1, 0, 'h310, 'h311, 'h312, 3, 0, 0, 1, 4, 1, 1, 0, 0, 0, 'h000, 'h000, 'h000, 0, 0, 0, 0, 0, 0, 0};

        drive(tbl[0]);
        @(posedge clk);

        for (int i = 0; i < NVEC; i++) begin
            apply(tbl[i], i);
        end

        // Saturation: 255 flushes reach the ceiling, 45 more must not wrap.
        @(negedge clk);
        reset      = 1'b0;
        bus.enable = 1'b1;
        bus.flush  = 1'b1;
        for (int i = 0; i < 255; i++) begin
            @(posedge clk);
        end
        #1;
        chk("bubble_count_at_255", 100, int'(bus.bubble_count), 255);
        chk("valid_em_after_flush", 100, int'(bus.valid_em), 0);
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
        end
        #1;
        chk("bubble_count_saturated", 101, int'(bus.bubble_count), 255);

        @(negedge clk);
        bus.flush                       = 1'b0;
        bus.alu_source_1_data_forwarded = 10'h1C3;
        bus.reg_dest_addr_fd            = 3'd6;
        @(posedge clk);
        #1;
        chk("bubble_count_hold_on_load", 102, int'(bus.bubble_count), 255);
        chk("valid_em_after_load",       102, int'(bus.valid_em), 1);
        chk("alu_source_1_after_load",   102, int'(bus.alu_source_1_data_em), 'h1C3);
        chk("reg_dest_after_load",       102, int'(bus.reg_dest_addr_em), 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
